uart_tx_serializer: RTL and testbench

// - Asynchronous-serial (8N1-style) transmitter; downstream consumer of the pulse_generator baud tick.
// - Accepts parallel words over a valid/ready handshake.
// - Shifts each word out LSB-first on tx as: start bit, data bits, optional parity bit, stop bit(s).
// - Every serial bit lasts exactly one tick period; tx only changes on a clock edge where tick==1.

---
 rtl/uart_pkg.sv | 22 ++
 rtl/register.sv | 19 +
 rtl/shift_register_piso.sv | 28 ++
 rtl/uart_tx_serializer.sv | 143 ++++++++++++++
 tb/tb_uart_tx_serializer.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART transmit path.
package uart_pkg;

   localparam logic [1:0] PARITY_NONE = 2'd0;
   localparam logic [1:0] PARITY_EVEN = 2'd1;
   localparam logic [1:0] PARITY_ODD  = 2'd2;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ARMED,
      ST_START,
      ST_DATA,
      ST_PAR,
      ST_STOP
   } uart_tx_state_t;

   // Zero-extension of narrower words is harmless: extra zeros do not change the XOR.
   function automatic logic parity_bit(input logic [8:0] d, input logic [1:0] mode);
      return (^d) ^ (mode == PARITY_ODD);
   endfunction

endpackage

// File: rtl/register.sv
// Enabled register with synchronous active-low clear.
module register #(
   parameter int W = 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         en,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   always_ff @(posedge clk) begin
      if (!rst)
         q <= '0;
      else if (en)
         q <= d;
   end

endmodule

// File: rtl/shift_register_piso.sv
// Parallel-in serial-out right shifter; exposes the current and following LSB.
module shift_register_piso #(
   parameter int N = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic         shift,
   input  logic [N-1:0] d,
   output logic         lsb,
   output logic         lsb_next
);

   logic [N-1:0] q;

   always_ff @(posedge clk) begin
      if (!rst)
         q <= '0;
      else if (load)
         q <= d;
      else if (shift)
         q <= {1'b0, q[N-1:1]};
   end

   assign lsb      = q[0];
   assign lsb_next = q[1];

endmodule

// File: rtl/uart_tx_serializer.sv
// Tick-paced asynchronous serial transmitter: start, LSB-first data, optional parity, stop bits.
module uart_tx_serializer
   import uart_pkg::*;
#(
   parameter int         DATA_BITS = 8,
   parameter int         STOP_BITS = 1,
   parameter logic [1:0] PARITY    = PARITY_NONE
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 tick,
   input  logic [DATA_BITS-1:0] data,
   input  logic                 valid,
   output logic                 ready,
   output logic                 tx,
   output logic                 busy,
   output logic                 done
);

   localparam int BW = $clog2(DATA_BITS);

   uart_tx_state_t state, state_nx;
   logic           tx_q, tx_nx, done_q, done_nx, par_q;
   logic           load, shift, bit_clr, bit_inc, stop_clr, stop_inc;
   logic           sr_lsb, sr_next;
   logic [BW-1:0]  bit_cnt;
   logic           stop_cnt;
   logic           last_bit, last_stop, accept;

   shift_register_piso #(.N(DATA_BITS)) u_sr (
      .clk      (clk),
      .rst      (rst),
      .load     (load),
      .shift    (shift),
      .d        (data),
      .lsb      (sr_lsb),
      .lsb_next (sr_next)
   );

   register #(.W(BW)) u_bit_cnt (
      .clk (clk),
      .rst (rst),
      .en  (bit_clr | bit_inc),
      .d   (bit_clr ? '0 : bit_cnt + BW'(1)),
      .q   (bit_cnt)
   );

   register #(.W(1)) u_stop_cnt (
      .clk (clk),
      .rst (rst),
      .en  (stop_clr | stop_inc),
      .d   (stop_clr ? 1'b0 : ~stop_cnt),
      .q   (stop_cnt)
   );

   assign last_bit  = (bit_cnt == BW'(DATA_BITS - 1));
   assign last_stop = (stop_cnt == 1'(STOP_BITS - 1));
   // Ready opens on the final stop tick too, so a waiting word chains with no idle gap.
   assign ready     = rst & ((state == ST_IDLE) | ((state == ST_STOP) & last_stop & tick));
   assign accept    = valid & ready;
   assign busy      = (state != ST_IDLE);
   assign tx        = tx_q;
   assign done      = done_q;

   always_ff @(posedge clk) begin
      if (!rst) begin
         state  <= ST_IDLE;
         tx_q   <= 1'b1;
         done_q <= 1'b0;
         par_q  <= 1'b0;
      end else begin
         state  <= state_nx;
         tx_q   <= tx_nx;
         done_q <= done_nx;
         if (load)
            par_q <= parity_bit(9'(data), PARITY);
      end
   end

   always_comb begin
      state_nx = state;
      tx_nx    = tx_q;
      done_nx  = 1'b0;
      load     = 1'b0;
      shift    = 1'b0;
      bit_clr  = 1'b0;
      bit_inc  = 1'b0;
      stop_clr = 1'b0;
      stop_inc = 1'b0;
      case (state)
         ST_IDLE: if (accept) begin
            load     = 1'b1;
            state_nx = ST_ARMED;
         end
         ST_ARMED: if (tick) begin
            tx_nx    = 1'b0;
            state_nx = ST_START;
         end
         ST_START: if (tick) begin
            tx_nx    = sr_lsb;
            bit_clr  = 1'b1;
            state_nx = ST_DATA;
         end
         ST_DATA: if (tick) begin
            if (last_bit) begin
               stop_clr = 1'b1;
               if (PARITY != PARITY_NONE) begin
                  tx_nx    = par_q;
                  state_nx = ST_PAR;
               end else begin
                  tx_nx    = 1'b1;
                  state_nx = ST_STOP;
               end
            end else begin
               shift   = 1'b1;
               bit_inc = 1'b1;
               tx_nx   = sr_next;
            end
         end
         ST_PAR: if (tick) begin
            tx_nx    = 1'b1;
            stop_clr = 1'b1;
            state_nx = ST_STOP;
         end
         ST_STOP: if (tick) begin
            if (last_stop) begin
               done_nx = 1'b1;
               if (accept) begin
                  load     = 1'b1;
                  tx_nx    = 1'b0;
                  state_nx = ST_START;
               end else begin
                  state_nx = ST_IDLE;
               end
            end else begin
               stop_inc = 1'b1;
            end
         end
         default: state_nx = ST_IDLE;
      endcase
   end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Directed bench: three serializer configurations driven by a 1-in-4 baud tick.
module tb_uart_tx_serializer;
   import uart_pkg::*;

   logic       clk, rst;
   logic [7:0] data;
   logic       valid_a, valid_e, valid_o;
   logic       ready_a, ready_e, ready_o;
   logic       tx_a, tx_e, tx_o;
   logic       busy_a, busy_e, busy_o;
   logic       done_a, done_e, done_o;
   logic       tx_s, busy_s, done_s, ready_s;
   logic [1:0] tcnt = 2'd0;
   logic       tick;
   int         sel;
   int         ntests, nfail;

   typedef struct {
      int          sel;
      logic [7:0]  data;
      logic [23:0] fr;
      int          n;
   } vec_t;
   vec_t vecs[9];

   // a: no parity, 1 stop; e: even parity, 2 stop; o: odd parity, 1 stop
   uart_tx_serializer #(.DATA_BITS(8), .STOP_BITS(1), .PARITY(PARITY_NONE)) u_a (
      .clk(clk), .rst(rst), .tick(tick), .data(data), .valid(valid_a),
      .ready(ready_a), .tx(tx_a), .busy(busy_a), .done(done_a));
   uart_tx_serializer #(.DATA_BITS(8), .STOP_BITS(2), .PARITY(PARITY_EVEN)) u_e (
      .clk(clk), .rst(rst), .tick(tick), .data(data), .valid(valid_e),
      .ready(ready_e), .tx(tx_e), .busy(busy_e), .done(done_e));
   uart_tx_serializer #(.DATA_BITS(8), .STOP_BITS(1), .PARITY(PARITY_ODD)) u_o (
      .clk(clk), .rst(rst), .tick(tick), .data(data), .valid(valid_o),
      .ready(ready_o), .tx(tx_o), .busy(busy_o), .done(done_o));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) tcnt <= tcnt + 2'd1;
   assign tick = (tcnt == 2'd3);

   always_comb begin
      case (sel)
         1:       begin tx_s = tx_e; busy_s = busy_e; done_s = done_e; ready_s = ready_e; end
         2:       begin tx_s = tx_o; busy_s = busy_o; done_s = done_o; ready_s = ready_o; end
         default: begin tx_s = tx_a; busy_s = busy_a; done_s = done_a; ready_s = ready_a; end
      endcase
   end

   task automatic chk(input logic [31:0] act, input logic [31:0] exp, input string nm);
      ntests++;
      if (act !== exp) begin
         nfail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic timeout(input string nm);
      ntests++;
      nfail++;
      $display("FAIL %s: tick timeout", nm);
   endtask

   task automatic set_valid(input int s, input logic v);
      valid_a = v && (s == 0);
      valid_e = v && (s == 1);
      valid_o = v && (s == 2);
   endtask

   // One-cycle valid pulse into an idle DUT; data is scrambled afterwards.
   task automatic send(input int s, input logic [7:0] d, input string nm);
      @(posedge clk); #1;
      sel  = s;
      data = d;
      set_valid(s, 1'b1);
      @(negedge clk);
      chk(ready_s, 1, {nm, " ready idle"});
      @(posedge clk); #1;
      set_valid(s, 1'b0);
      data = ~d;
   endtask

   task automatic wait_tick_edge(input string nm);
      int k = 0;
      while (tick !== 1'b1 && k < 64) begin
         @(negedge clk); k++;
      end
      if (tick !== 1'b1) timeout(nm);
      @(posedge clk); #1;
   endtask

   // Checks each bit right after its starting tick edge and just before the next one.
   task automatic expect_bits(input logic [23:0] fr, input int n, input string nm,
                              output int dones, output int busyc);
      int k;
      bit started;
      dones = 0; busyc = 0; started = 0;
      for (int i = 0; i <= n; i++) begin
         k = 0;
         while (tick !== 1'b1 && k < 64) begin
            @(negedge clk); k++;
            if (done_s) dones++;
            if (started && busy_s) busyc++;
         end
         if (tick !== 1'b1) begin
            timeout(nm);
            return;
         end
         if (i > 0) chk(tx_s, fr[i-1], $sformatf("%s hold bit%0d", nm, i - 1));
         @(posedge clk); @(negedge clk);
         started = 1;
         if (done_s) dones++;
         if (i < n) begin
            if (busy_s) busyc++;
            chk(tx_s, fr[i], $sformatf("%s bit%0d", nm, i));
         end
      end
   endtask

   task automatic post_frame(input int dones, input int busyc, input int exp_dones,
                             input int n, input string nm);
      chk(dones, exp_dones, {nm, " done count"});
      chk(busyc, 4 * n, {nm, " busy clocks"});
      chk(tx_s, 1, {nm, " tx idle"});
      chk(busy_s, 0, {nm, " busy end"});
      chk(ready_s, 1, {nm, " ready end"});
      @(negedge clk);
      chk(done_s, 0, {nm, " done width"});
   endtask

   initial begin
      int dones, busyc;
      ntests = 0; nfail = 0; sel = 0;
      rst = 1'b0; data = 8'h00;
      valid_a = 1'b0; valid_e = 1'b0; valid_o = 1'b0;

      vecs[0] = '{0, 8'hA5, 24'({1'b1, 8'hA5, 1'b0}), 10};
      vecs[1] = '{0, 8'h00, 24'({1'b1, 8'h00, 1'b0}), 10};
      vecs[2] = '{0, 8'hFF, 24'({1'b1, 8'hFF, 1'b0}), 10};
      vecs[3] = '{1, 8'h07, 24'({2'b11, 1'b1, 8'h07, 1'b0}), 12};
      vecs[4] = '{2, 8'h07, 24'({1'b1, 1'b0, 8'h07, 1'b0}), 11};
      vecs[5] = '{1, 8'h00, 24'({2'b11, 1'b0, 8'h00, 1'b0}), 12};
      vecs[6] = '{2, 8'h00, 24'({1'b1, 1'b1, 8'h00, 1'b0}), 11};
      vecs[7] = '{1, 8'h80, 24'({2'b11, 1'b1, 8'h80, 1'b0}), 12};
      vecs[8] = '{2, 8'hFE, 24'({1'b1, 1'b0, 8'hFE, 1'b0}), 11};

      // reset state
      repeat (3) @(posedge clk);
      for (int s = 0; s < 3; s++) begin
         #1 sel = s;
         @(negedge clk);
         chk(tx_s, 1, $sformatf("rst tx u%0d", s));
         chk(busy_s, 0, $sformatf("rst busy u%0d", s));
         chk(done_s, 0, $sformatf("rst done u%0d", s));
         chk(ready_s, 0, $sformatf("rst ready u%0d", s));
      end
      @(posedge clk); #1 rst = 1'b1; sel = 0;
      @(negedge clk);
      chk(ready_s, 1, "ready after rst");

      // single frames across all configurations
      for (int v = 0; v < 9; v++) begin
         send(vecs[v].sel, vecs[v].data, $sformatf("vec%0d", v));
         expect_bits(vecs[v].fr, vecs[v].n, $sformatf("vec%0d", v), dones, busyc);
         post_frame(dones, busyc, 1, vecs[v].n, $sformatf("vec%0d", v));
      end

      // back-to-back frames with valid held
      @(posedge clk); #1;
      sel = 0; data = 8'h55; valid_a = 1'b1;
      @(negedge clk);
      chk(ready_s, 1, "b2b ready");
      @(posedge clk); #1 data = 8'h0F;
      fork
         expect_bits(24'({1'b1, 8'h0F, 1'b0, 1'b1, 8'h55, 1'b0}), 20, "b2b", dones, busyc);
         begin
            repeat (50) @(posedge clk);
            #1 valid_a = 1'b0;
         end
      join
      post_frame(dones, busyc, 2, 20, "b2b");

      // reset during data bit 3 of 0x96
      send(0, 8'h96, "rstmid");
      for (int e = 0; e < 5; e++) wait_tick_edge("rstmid edge");
      rst = 1'b0;
      @(negedge clk);
      chk(tx_s, 0, "rstmid d3 before");
      chk(ready_s, 0, "rstmid ready in rst");
      @(posedge clk); @(negedge clk);
      chk(tx_s, 1, "rstmid tx");
      chk(busy_s, 0, "rstmid busy");
      chk(ready_s, 0, "rstmid ready held");
      @(posedge clk); #1 rst = 1'b1;
      @(negedge clk);
      chk(ready_s, 1, "rstmid ready release");
      send(0, 8'h3C, "after rst");
      expect_bits(24'({1'b1, 8'h3C, 1'b0}), 10, "after rst", dones, busyc);
      post_frame(dones, busyc, 1, 10, "after rst");

      // accept in the same cycle as a tick
      begin
         int k = 0;
         do begin
            @(posedge clk); #1; k++;
         end while (tick !== 1'b1 && k < 16);
      end
      sel = 0; data = 8'hC3; valid_a = 1'b1;
      @(negedge clk);
      chk(ready_s, 1, "cotick ready");
      @(posedge clk); #1 valid_a = 1'b0; data = 8'h00;
      @(negedge clk);
      chk(busy_s, 1, "cotick busy");
      chk(tx_s, 1, "cotick no start");
      expect_bits(24'({1'b1, 8'hC3, 1'b0}), 10, "cotick", dones, busyc);
      post_frame(dones, busyc, 1, 10, "cotick");

      // valid and new data while busy are ignored
      send(0, 8'h5A, "busyv");
      fork
         expect_bits(24'({1'b1, 8'h5A, 1'b0}), 10, "busyv", dones, busyc);
         begin
            repeat (12) @(posedge clk);
            #1 data = 8'hFF; valid_a = 1'b1;
            @(negedge clk);
            chk(ready_s, 0, "busyv ready");
            chk(busy_s, 1, "busyv busy");
            @(posedge clk); #1 valid_a = 1'b0;
         end
      join
      post_frame(dones, busyc, 1, 10, "busyv");

      $display("[TB] %0d tests run, %0d failed", ntests, nfail);
      $finish;
   end

endmodule
